// File: rtl/lbp_pkg.sv
// Shared types for the streaming LBP engine.
// FSM encoding and neighbour bit positions within the LBP code.
package lbp_pkg;

  typedef enum logic [1:0] {
    ST_READ,
    ST_FLUSH,
    ST_DONE
  } lbp_state_e;

  localparam int NB_TL = 0;
  localparam int NB_T  = 1;
  localparam int NB_TR = 2;
  localparam int NB_L  = 3;
  localparam int NB_R  = 4;
  localparam int NB_BL = 5;
  localparam int NB_B  = 6;
  localparam int NB_BR = 7;
  localparam int NB_N  = 8;

endpackage

// File: rtl/lbp_line_buf.sv
// Two-row line buffer sharing one index; reads return the
// pre-write contents, so row1 is two rows up and row0 one row up.
module lbp_line_buf #(
  parameter  int DEPTH = 128,
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IW-1:0]    idx_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] row0_o,
  output logic [WIDTH-1:0] row1_o
);

  logic [WIDTH-1:0] r0_q [DEPTH];
  logic [WIDTH-1:0] r1_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      r0_q[idx_i] <= din_i;
      r1_q[idx_i] <= r0_q[idx_i];
    end
  end

  assign row0_o = r0_q[idx_i];
  assign row1_o = r1_q[idx_i];

endmodule

// File: rtl/lbp_stream.sv
// Streaming 3x3 LBP engine: raster read once, line buffers feed a
// sliding window, one registered LBP write per accepted pixel.
module lbp_stream
  import lbp_pkg::*;
#(
  parameter  int IMG_W        = 128,
  parameter  int IMG_H        = 128,
  parameter  int PIX_W        = 8,
  parameter  bit BORDER_WRITE = 1'b1,
  localparam int ADDR_W       = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [PIX_W-1:0]  gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int FW   = CW + 1;
  localparam int LAST = IMG_W*IMG_H - 1;
  localparam int FBAS = (IMG_H-1)*IMG_W;

  lbp_state_e        st_q;
  logic [CW-1:0]     c_q;
  logic [RW-1:0]     r_q;
  logic [ADDR_W-1:0] a_q;
  logic [FW-1:0]     fl_q;

  logic [PIX_W-1:0]  win_q [3][3];
  logic [PIX_W-1:0]  lb_top;
  logic [PIX_W-1:0]  lb_mid;

  logic              s1_v_q;
  logic              s1_b_q;
  logic [ADDR_W-1:0] s1_a_q;
  logic              s1_b_d;
  logic [ADDR_W-1:0] s1_a_d;
  logic [ADDR_W-1:0] fl_a_d;

  logic              vld_q;
  logic [ADDR_W-1:0] oa_q;
  logic [7:0]        od_q;
  logic              fin_q;

  logic [PIX_W-1:0]  nb [NB_N];
  logic [7:0]        code_d;

  assign gray_req  = reset & gray_ready
                   & (st_q == ST_READ);
  assign gray_addr = a_q;
  assign lbp_valid = vld_q;
  assign lbp_addr  = oa_q;
  assign lbp_data  = od_q;
  assign finish    = fin_q;

  lbp_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb (
    .clk    (clk),
    .we_i   (gray_req),
    .idx_i  (c_q),
    .din_i  (gray_data),
    .row0_o (lb_mid),
    .row1_o (lb_top)
  );

  // window index is [column][row]; column 1 row 1 is the centre
  assign nb[NB_TL] = win_q[0][0];
  assign nb[NB_T]  = win_q[1][0];
  assign nb[NB_TR] = win_q[2][0];
  assign nb[NB_L]  = win_q[0][1];
  assign nb[NB_R]  = win_q[2][1];
  assign nb[NB_BL] = win_q[0][2];
  assign nb[NB_B]  = win_q[1][2];
  assign nb[NB_BR] = win_q[2][2];

  always_comb begin
    code_d = '0;
    for (int k = 0; k < NB_N; k++) begin
      code_d[k] = (nb[k] >= win_q[1][1]);
    end
  end

  // target of the write triggered by accepting p(r,c)
  always_comb begin
    s1_a_d = a_q - ADDR_W'(IMG_W + 1);
    s1_b_d = 1'b0;
    unique case (1'b1)
      (c_q == '0): begin
        s1_a_d = a_q - ADDR_W'(1);
        s1_b_d = 1'b1;
      end
      ((c_q != '0) &&
       ((c_q == CW'(1)) || (r_q == RW'(1)))): begin
        s1_b_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign fl_a_d = ADDR_W'(FBAS) + ADDR_W'(fl_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= ST_READ;
      c_q    <= '0;
      r_q    <= '0;
      a_q    <= '0;
      fl_q   <= '0;
      s1_v_q <= 1'b0;
      s1_b_q <= 1'b0;
      s1_a_q <= '0;
      vld_q  <= 1'b0;
      oa_q   <= '0;
      od_q   <= '0;
      fin_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      s1_v_q <= 1'b0;
      unique case (st_q)
        ST_READ: begin
          if (gray_req) begin
            for (int j = 0; j < 3; j++) begin
              win_q[0][j] <= win_q[1][j];
              win_q[1][j] <= win_q[2][j];
            end
            win_q[2][0] <= lb_top;
            win_q[2][1] <= lb_mid;
            win_q[2][2] <= gray_data;
            s1_v_q <= (r_q != '0);
            s1_b_q <= s1_b_d;
            s1_a_q <= s1_a_d;
            if (a_q == ADDR_W'(LAST)) begin
              st_q <= ST_FLUSH;
            end else begin
              a_q <= a_q + ADDR_W'(1);
              if (c_q == CW'(IMG_W-1)) begin
                c_q <= '0;
                r_q <= r_q + RW'(1);
              end else begin
                c_q <= c_q + CW'(1);
              end
            end
          end
        end
        ST_FLUSH: begin
          if (BORDER_WRITE &&
              (fl_q != FW'(IMG_W))) begin
            s1_v_q <= 1'b1;
            s1_b_q <= 1'b1;
            s1_a_q <= fl_a_d;
            fl_q   <= fl_q + FW'(1);
          end else begin
            st_q <= ST_DONE;
          end
        end
        ST_DONE: ;
        default: st_q <= ST_READ;
      endcase
      vld_q <= s1_v_q &
               (BORDER_WRITE | ~s1_b_q);
      if (s1_v_q) begin
        oa_q <= s1_a_q;
        od_q <= s1_b_q ? 8'h00 : code_d;
      end
      fin_q <= (st_q == ST_DONE);
    end
  end

endmodule

// File: tb/tb_lbp_stream.sv
// Bench for lbp_stream: three configurations checked each cycle
// against a frame-level LBP model, plus literal pins.
module tb_lbp_stream;

  localparam int W_OF  [3] = '{128, 5, 128};
  localparam int H_OF  [3] = '{128, 4, 128};
  localparam int BW_OF [3] = '{1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
  int   ph_a = 0, ph_b = 0;

  logic [7:0] img_a [16384];
  logic [7:0] img_b [32];
  logic [7:0] img_c [16384];

  logic req_a, vld_a, fin_a;
  logic [13:0] ga_a, la_a;
  logic [7:0] gd_a, ld_a;
  logic req_b, vld_b, fin_b;
  logic [4:0] ga_b, la_b;
  logic [7:0] gd_b, ld_b;
  logic req_c, vld_c, fin_c;
  logic [13:0] ga_c, la_c;
  logic [7:0] gd_c, ld_c;

  assign gd_a = img_a[ga_a];
  assign gd_b = img_b[ga_b];
  assign gd_c = img_c[ga_c];

  lbp_stream dut_a (
    .clk(clk), .reset(rst_a), .gray_ready(rdy_a),
    .gray_req(req_a), .gray_addr(ga_a), .gray_data(gd_a),
    .lbp_valid(vld_a), .lbp_addr(la_a), .lbp_data(ld_a),
    .finish(fin_a));

  lbp_stream #(.IMG_W(5), .IMG_H(4)) dut_b (
    .clk(clk), .reset(rst_b), .gray_ready(rdy_b),
    .gray_req(req_b), .gray_addr(ga_b), .gray_data(gd_b),
    .lbp_valid(vld_b), .lbp_addr(la_b), .lbp_data(ld_b),
    .finish(fin_b));

  lbp_stream #(.BORDER_WRITE(1'b0)) dut_c (
    .clk(clk), .reset(rst_c), .gray_ready(rdy_c),
    .gray_req(req_c), .gray_addr(ga_c), .gray_data(gd_c),
    .lbp_valid(vld_c), .lbp_addr(la_c), .lbp_data(ld_c),
    .finish(fin_c));

  logic        req_v [3], vld_v [3], fin_v [3];
  logic [13:0] ga_v [3], la_v [3];
  logic [7:0]  ld_v [3];

  assign req_v[0] = req_a;
  assign req_v[1] = req_b;
  assign req_v[2] = req_c;
  assign vld_v[0] = vld_a;
  assign vld_v[1] = vld_b;
  assign vld_v[2] = vld_c;
  assign fin_v[0] = fin_a;
  assign fin_v[1] = fin_b;
  assign fin_v[2] = fin_c;
  assign ga_v[0]  = ga_a;
  assign ga_v[1]  = {9'd0, ga_b};
  assign ga_v[2]  = ga_c;
  assign la_v[0]  = la_a;
  assign la_v[1]  = {9'd0, la_b};
  assign la_v[2]  = la_c;
  assign ld_v[0]  = ld_a;
  assign ld_v[1]  = ld_b;
  assign ld_v[2]  = ld_c;

  int checks = 0;
  int errors = 0;
  int cur_g, cur_t;

  int nacc [3], tcy [3], last_t [3], nw [3];
  bit h1v [3], h2v [3];
  int h1a [3], h2a [3];
  bit wr [3][16384];
  logic [7:0] mem [3][16384];

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut=%0d cycle=%0d actual=%0h required=%0h",
               nm, cur_g, cur_t, act, req);
    end
  endtask

  function automatic int pix(int g, int i);
    case (g)
      0: return int'(img_a[i]);
      1: return int'(img_b[i]);
      default: return int'(img_c[i]);
    endcase
  endfunction

  function automatic bit is_border(int g, int a);
    int x = a % W_OF[g];
    int y = a / W_OF[g];
    return (y == 0) || (y == H_OF[g]-1) ||
           (x == 0) || (x == W_OF[g]-1);
  endfunction

  function automatic int lbp_exp(int g, int a);
    int w = W_OF[g];
    int x = a % w;
    int y = a / w;
    int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int cv, code;
    if (is_border(g, a)) return 0;
    cv = pix(g, a);
    code = 0;
    for (int k = 0; k < 8; k++) begin
      if (pix(g, (y+dy[k])*w + x + dx[k]) >= cv)
        code = code | (1 << k);
    end
    return code;
  endfunction

  function automatic bit rst_of(int g);
    case (g)
      0: return rst_a;
      1: return rst_b;
      default: return rst_c;
    endcase
  endfunction

  function automatic bit rdy_of(int g);
    case (g)
      0: return rdy_a;
      1: return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  task automatic frame_end(int g);
    int w = W_OF[g], h = H_OF[g];
    int tot = (BW_OF[g] != 0) ? w*h : (w-2)*(h-2);
    chk("write_count", nw[g], tot);
    case (g)
      0: if (ph_a == 0) begin
        chk("A_finish_cycle", cur_t, 16514);
        chk("A_mem_1_1", int'(mem[0][129]), 'hFF);
        chk("A_mem_0_0", int'(mem[0][0]), 'h00);
        chk("A_mem_127_5", int'(mem[0][16261]), 'h00);
        chk("A_model_pin", lbp_exp(0, 129), 'hFF);
      end
      1: if (ph_b == 0) begin
        chk("B_mem_1_1", int'(mem[1][6]), 'hD6);
        chk("B_mem_1_3", int'(mem[1][8]), 'hD6);
        chk("B_mem_0_0", int'(mem[1][0]), 'h00);
        chk("B_mem_3_4", int'(mem[1][19]), 'h00);
        chk("B_model_pin", lbp_exp(1, 7), 'hD6);
      end else begin
        chk("B_spike", int'(mem[1][6]), 'h00);
        chk("B_spike_r", int'(mem[1][7]), 'hFF);
        chk("B_spike_br", int'(mem[1][12]), 'hFF);
        chk("B_spike_far", int'(mem[1][13]), 'hFF);
        chk("B_model_spike", lbp_exp(1, 6), 'h00);
      end
      default: begin
        chk("C_border_untouched", int'(wr[2][0]), 0);
        chk("C_interior_written", int'(wr[2][129]), 1);
      end
    endcase
  endtask

  task automatic step(int g);
    int w = W_OF[g], h = H_OF[g], wh = W_OF[g]*H_OF[g];
    bit bw = (BW_OF[g] != 0);
    bit ereq, ev, efin;
    int ea, ed, r, c, t, tf, la;
    cur_g = g;
    cur_t = tcy[g];
    if (!rst_of(g)) begin
      chk("rst_gray_req", int'(req_v[g]), 0);
      chk("rst_gray_addr", int'(ga_v[g]), 0);
      chk("rst_lbp_valid", int'(vld_v[g]), 0);
      chk("rst_lbp_addr", int'(la_v[g]), 0);
      chk("rst_lbp_data", int'(ld_v[g]), 0);
      chk("rst_finish", int'(fin_v[g]), 0);
      nacc[g] = 0; tcy[g] = 0; last_t[g] = -1; nw[g] = 0;
      h1v[g] = 0; h2v[g] = 0;
      for (int i = 0; i < 16384; i++) wr[g][i] = 0;
      return;
    end
    t = tcy[g];
    ereq = rdy_of(g) && (nacc[g] < wh);
    chk("gray_req", int'(req_v[g]), int'(ereq));
    if (ereq) chk("gray_addr", int'(ga_v[g]), nacc[g]);
    ev = 0; ea = 0; ed = 0;
    if (h2v[g]) begin
      r = h2a[g] / w;
      c = h2a[g] % w;
      if (r >= 1) begin
        ea = (c == 0) ? (r-1)*w + w-1 : (r-1)*w + c-1;
        ev = bw || !is_border(g, ea);
        ed = lbp_exp(g, ea);
      end
    end
    if (last_t[g] >= 0 && bw && t >= last_t[g]+3 &&
        t <= last_t[g]+2+w) begin
      ev = 1;
      ea = (h-1)*w + t - last_t[g] - 3;
      ed = 0;
    end
    chk("lbp_valid", int'(vld_v[g]), int'(ev));
    if (vld_v[g]) begin
      la = int'(la_v[g]);
      if (ev) begin
        chk("lbp_addr", la, ea);
        chk("lbp_data", int'(ld_v[g]), ed);
      end
      chk("dup_write", int'(wr[g][la]), 0);
      wr[g][la] = 1;
      mem[g][la] = ld_v[g];
      nw[g]++;
    end
    tf = last_t[g] + 3 + (bw ? w : 0);
    efin = (last_t[g] >= 0) && (t >= tf);
    chk("finish", int'(fin_v[g]), int'(efin));
    if (last_t[g] >= 0 && t == tf) frame_end(g);
    h2v[g] = h1v[g];
    h2a[g] = h1a[g];
    h1v[g] = ereq;
    h1a[g] = nacc[g];
    if (ereq) begin
      nacc[g]++;
      if (nacc[g] == wh) last_t[g] = t;
    end
    tcy[g]++;
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) step(g);
  end

  task automatic wait_fin(int g, int budget);
    int n = 0;
    while (!fin_v[g]) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        $display("FAIL timeout dut=%0d waiting for finish", g);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic wait_addr(int g, int a, int budget);
    int n = 0;
    while (!(req_v[g] && int'(ga_v[g]) == a)) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        $display("FAIL timeout dut=%0d waiting for addr %0d", g, a);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      img_a[i] = 8'h55;
      img_c[i] = 8'($urandom);
    end
    for (int i = 0; i < 32; i++)
      img_b[i] = (i < 20) ? 8'((i % 5) * 10) : 8'h00;
    #1;
    rst_a = 0; rst_b = 0; rst_c = 0;
    cycles(3);
    fork
      begin
        rst_a = 1; rdy_a = 1;
        wait_fin(0, 17000);
        cycles(2);
        rst_a = 0; ph_a = 1;
        for (int i = 0; i < 16384; i++) img_a[i] = 8'($urandom);
        cycles(2);
        rst_a = 1;
        wait_addr(0, 5000, 6000);
        rst_a = 0;
        cycles(3);
        rst_a = 1;
        wait_addr(0, 3*128+60, 1000);
        rdy_a = 0;
        cycles(5);
        rdy_a = 1;
        wait_addr(0, 7*128, 1000);
        rdy_a = 0;
        cycles(5);
        rdy_a = 1;
        wait_fin(0, 17000);
      end
      begin
        rst_b = 1; rdy_b = 1;
        wait_fin(1, 200);
        cycles(2);
        rst_b = 0; ph_b = 1;
        for (int i = 0; i < 20; i++) img_b[i] = 8'd10;
        img_b[6] = 8'd200;
        cycles(2);
        rst_b = 1;
        wait_addr(1, 9, 50);
        rdy_b = 0;
        cycles(3);
        rdy_b = 1;
        wait_fin(1, 200);
      end
      begin
        rst_c = 1; rdy_c = 1;
        wait_fin(2, 17000);
      end
    join
    cycles(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
